// File: rtl/pinball_pkg.sv
// Shared game-state encodings, hole geometry and detector FSM states for the
// pinball scoring path.
package pinball_pkg;

    localparam logic [2:0] RESET = 3'd0;
    localparam logic [2:0] WAIT  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] GET   = 3'd3;
    localparam logic [2:0] OVER  = 3'd4;

    localparam int NUM_HOLES = 8;

    typedef enum logic [1:0] {
        DET_IDLE     = 2'd0,
        DET_ARMED    = 2'd1,
        DET_HOLD     = 2'd2,
        DET_COOLDOWN = 2'd3
    } det_state_t;

    // Hole k sits on vector bit 7-k.
    function automatic logic [2:0] hole_to_bit(input logic [2:0] k);
        return 3'(NUM_HOLES - 1) - k;
    endfunction

endpackage

// File: rtl/hole_debounce.sv
// One sensor line: two-flop synchroniser, saturating high-time counter and
// a rising-edge detector on the debounced level.
module hole_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb_q <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != CW'(DEB_CYCLES))
                cnt <= cnt + 1'b1;
            deb_q <= deb;
        end
    end

    assign deb  = (cnt == CW'(DEB_CYCLES));
    assign rise = deb & ~deb_q;

endmodule

// File: rtl/ball_hole_detector.sv
// Debounces the hole sensors and captures exactly one hole per ball into a
// one-hot vector that is held steady until the game FSM has scored it.
module ball_hole_detector
    import pinball_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int HOLD_TIMEOUT = 64,
    parameter int COOL_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] state,
    input  logic [7:0] hole_raw,
    output logic [7:0] getball,
    output logic       ball_in,
    output logic [2:0] hole_id,
    output logic       err_multi
);

    localparam int HW = $clog2(HOLD_TIMEOUT);
    localparam int CW = $clog2(COOL_CYCLES + 1);

    logic [NUM_HOLES-1:0] deb;
    logic [NUM_HOLES-1:0] rise;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_deb
        hole_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (hole_raw[i]),
            .deb   (deb[i]),
            .rise  (rise[i])
        );
    end

    det_state_t    fsm, fsm_next;
    logic [7:0]    getball_next;
    logic [2:0]    hole_id_next;
    logic          ball_in_next, err_multi_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [CW-1:0] cool_cnt, cool_next;
    logic          seen_get, seen_next;
    logic [2:0]    sel_hole;
    logic [7:0]    sel_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= DET_IDLE;
            getball   <= '0;
            hole_id   <= '0;
            ball_in   <= 1'b0;
            err_multi <= 1'b0;
            hold_cnt  <= '0;
            cool_cnt  <= '0;
            seen_get  <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            getball   <= getball_next;
            hole_id   <= hole_id_next;
            ball_in   <= ball_in_next;
            err_multi <= err_multi_next;
            hold_cnt  <= hold_next;
            cool_cnt  <= cool_next;
            seen_get  <= seen_next;
        end
    end

    always_comb begin
        fsm_next       = fsm;
        getball_next   = getball;
        hole_id_next   = hole_id;
        ball_in_next   = 1'b0;
        err_multi_next = 1'b0;
        hold_next      = hold_cnt;
        cool_next      = cool_cnt;
        seen_next      = seen_get;

        // Scan from the highest hole down so the lowest hole number wins.
        sel_hole = '0;
        for (int k = NUM_HOLES - 1; k >= 0; k--)
            if (rise[hole_to_bit(3'(k))])
                sel_hole = 3'(k);
        sel_onehot = '0;
        sel_onehot[hole_to_bit(sel_hole)] = 1'b1;

        if (state == RESET || state == OVER) begin
            fsm_next     = DET_IDLE;
            getball_next = '0;
            hole_id_next = '0;
            hold_next    = '0;
            cool_next    = '0;
            seen_next    = 1'b0;
        end else begin
            case (fsm)
                DET_IDLE: begin
                    getball_next = '0;
                    if (state == START && deb == '0)
                        fsm_next = DET_ARMED;
                end
                DET_ARMED: begin
                    if (state != START) begin
                        fsm_next = DET_IDLE;
                    end else if (rise != '0) begin
                        getball_next   = sel_onehot;
                        hole_id_next   = sel_hole;
                        ball_in_next   = 1'b1;
                        err_multi_next = ($countones(rise) > 1);
                        hold_next      = '0;
                        seen_next      = 1'b0;
                        fsm_next       = DET_HOLD;
                    end
                end
                DET_HOLD: begin
                    // GET takes priority over the timeout so the vector never moves during GET.
                    if (state == GET) begin
                        seen_next = 1'b1;
                    end else if (seen_get || hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                        getball_next = '0;
                        hole_id_next = '0;
                        cool_next    = '0;
                        seen_next    = 1'b0;
                        fsm_next     = DET_COOLDOWN;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
                DET_COOLDOWN: begin
                    getball_next = '0;
                    if (cool_cnt != CW'(COOL_CYCLES))
                        cool_next = cool_cnt + 1'b1;
                    else if (deb == '0)
                        fsm_next = (state == START) ? DET_ARMED : DET_IDLE;
                end
                default: fsm_next = DET_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ball_hole_detector.md
Name: ball_hole_detector

Overview:
Front end of the scoring path. Turns the 8 raw hole sensors into the one-hot `getball` vector and the `ball_in` event that the game FSM and the score block consume.
- Synchronises and debounces each sensor.
- Arms only while the game is in START.
- Captures exactly one hole per ball and holds `getball` stable through the GET state, so scoring sees a clean, single-cycle-valid vector.

Parameters:
- DEB_CYCLES, 16: consecutive synchronised-high cycles before a hole counts as hit.
- HOLD_TIMEOUT, 64: cycles `getball` is held waiting for state==GET before it is abandoned.
- COOL_CYCLES, 32: minimum cycles in COOLDOWN after release before re-arming.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- state, input, 3: game state (RESET=0, WAIT=1, START=2, GET=3, OVER=4).
- hole_raw, input, 8: raw sensor lines, active-high, asynchronous. Bit 7-k is hole k.
- getball, output, 8: one-hot captured hole, same bit mapping (hole 0 = bit 7, hole 7 = bit 0). Zero when no capture.
- ball_in, output, 1: one-cycle pulse on capture. Requests the game FSM to enter GET.
- hole_id, output, 3: binary hole number k of the captured hole. Valid while `getball` is nonzero.
- err_multi, output, 1: one-cycle pulse when two or more holes qualify in the capture cycle.

Behaviour:
- Reset (rst_n low, async): `getball`=0, `ball_in`=0, `hole_id`=0, `err_multi`=0, FSM=IDLE. Synchronisers and debounce counters are cleared.
- Input path: 2-flop synchroniser per bit, then the debouncer.
  - Counter width: clog2(DEB_CYCLES+1).
  - Counter increments while the synchronised bit is 1 and saturates at DEB_CYCLES. Any synchronised 0 clears it.
  - `deb[i]`=1 when the counter equals DEB_CYCLES.
  - `rise[i]` = `deb[i]` & ~`deb_q[i]`.
  - Latency from a raw edge to `rise`: 2 + DEB_CYCLES cycles.
- FSM states: IDLE, ARMED, HOLD, COOLDOWN.
- IDLE
  - `getball`=0.
  - Go to ARMED when state==START and all `deb` bits are 0.
  - If a `deb` bit is high while entering START, stay in IDLE until all `deb` bits are 0. A stuck sensor must never score.
- ARMED
  - If state!=START, go to IDLE.
  - Else, if any `rise` bit is set:
    - Capture the highest set bit of `rise` (lowest hole number) into `getball` and its hole number into `hole_id`. Both are registered, so they are visible in the cycle after the `rise`.
    - Pulse `ball_in` in that same cycle.
    - Pulse `err_multi` in that same cycle if popcount(`rise`)>1.
    - Go to HOLD.
- HOLD
  - `getball` and `hole_id` stay frozen.
  - Track a `seen_get` flag. Once state==GET has been seen and state then changes, clear `getball` and go to COOLDOWN.
  - If GET is not seen within HOLD_TIMEOUT cycles of entering HOLD, clear `getball` and go to COOLDOWN with no score opportunity.
- COOLDOWN
  - `getball`=0.
  - Count COOL_CYCLES. After the count, wait until all `deb` bits are 0.
  - Then go to ARMED if state==START, else IDLE.
- Global override: state==RESET or state==OVER in any FSM state forces IDLE next cycle and clears `getball`, `hole_id` and the counters. A pending `ball_in` is not issued.
- Simultaneous events:
  - A `rise` in the same cycle as state leaving START is ignored.
  - Any `rise` during HOLD or COOLDOWN is ignored. There is no queueing: one ball gives one capture.
- `getball` is always one-hot or zero and never changes while state==GET.

Decomposition:
- `pinball_pkg`:
  - Game state constants RESET/WAIT/START/GET/OVER (3-bit).
  - NUM_HOLES=8.
  - Detector FSM state enum.
  - Function hole_to_bit(k)=7-k.
- Sub-module `hole_debounce`: synchroniser plus saturating counter for one bit, instantiated 8 times. Its outputs are `deb` and `rise`.

Test Plan:
1. Capture: state=START, hold hole_raw=8'b0010_0000 (hole 2) for 20 cycles → `ball_in` pulses at cycle 2+16+1. `getball`=8'b0010_0000 and `hole_id`=2, both stable through the following 3 GET cycles and 0 after GET exits.
2. Glitch rejection: state=START, hole 5 high for 10 cycles then low → no `ball_in`, `getball` stays 0.
3. Multi-hit: hole_raw=8'b0100_1000 (holes 1 and 4) asserted in the same cycle → `getball`=8'b0100_0000, `hole_id`=1, `err_multi` pulses once.
4. Timeout: capture hole 7 with state held at START → `getball`=8'b0000_0001 for 64 cycles then 0. A second hole hit in that window is ignored.
5. Stuck sensor: hole 0 high when state goes WAIT→START → FSM stays IDLE, no `ball_in` until hole 0 has been low for at least the 2-cycle synchroniser latency. A later clean hit on hole 3 captures 8'b0001_0000.
6. Abort: state switches to OVER during HOLD → `getball`=0 next cycle, FSM=IDLE. Async rst_n low mid-HOLD → all outputs 0 immediately.
